// File: rtl/gemm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gemm_pkg
// Description : Shared definitions for the sequenced GEMM engine. Holds the
//               default matrix geometry, the controller state encoding, the
//               accumulator-width rule and the packed-element index helper.
// Revision    : 1.0 - initial release
// ============================================================================
package gemm_pkg;

    localparam int DEF_N  = 2;   // matrix dimension
    localparam int DEF_W  = 8;   // element width
    localparam int DEF_SW = 8;   // alpha/beta width

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Worst case per element is N * (alpha*a*b + beta*c*d): two W*W*SW
    // products add one bit, the N-term sum adds clog2(N) more.
    function automatic int acc_w(input int w, input int sw, input int n);
        return 2 * w + sw + 1 + $clog2(n);
    endfunction

    // LSB position of element [row][col]; element [0][0] sits in the MSBs.
    function automatic int elem_lsb(input int n, input int w,
                                    input int row, input int col);
        return (n * n - 1 - (row * n + col)) * w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gemm_mac.sv
`default_nettype none
// ============================================================================
// Module      : gemm_mac
// Description : Combinational multiply-accumulate step of the GEMM engine:
//               acc_o = acc_i + alpha*a*b + beta*c*d, all unsigned, ACC_W wide.
// Ports       : alpha_i, beta_i  - per-job scalars (SW bits)
//               a_i, b_i, c_i, d_i - operand elements for this (i,j,k) term
//               acc_i             - running accumulator
//               acc_o             - updated accumulator
// Revision    : 1.0 - initial release
// ============================================================================
module gemm_mac
    import gemm_pkg::*;
#(
    parameter int W     = DEF_W,
    parameter int SW    = DEF_SW,
    parameter int ACC_W = acc_w(DEF_W, DEF_SW, DEF_N)
) (
    input  logic [SW-1:0]    alpha_i,
    input  logic [SW-1:0]    beta_i,
    input  logic [W-1:0]     a_i,
    input  logic [W-1:0]     b_i,
    input  logic [W-1:0]     c_i,
    input  logic [W-1:0]     d_i,
    input  logic [ACC_W-1:0] acc_i,
    output logic [ACC_W-1:0] acc_o
);

    logic [ACC_W-1:0] w_ab;
    logic [ACC_W-1:0] w_cd;

    // Operands are widened first so no product is truncated.
    assign w_ab  = ACC_W'(alpha_i) * ACC_W'(a_i) * ACC_W'(b_i);
    assign w_cd  = ACC_W'(beta_i)  * ACC_W'(c_i) * ACC_W'(d_i);
    assign acc_o = acc_i + w_ab + w_cd;

endmodule
`default_nettype wire

// File: rtl/gemm_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : gemm_ctrl
// Description : Sequenced GEMM engine, Cout = alpha*(AxB) + beta*(CxD) over
//               packed NxN unsigned matrices, one (i,j,k) term per clock on a
//               single shared MAC. Operands are captured with start; the
//               result is collected in a shadow and published to Cout in the
//               same cycle that done pulses.
// Ports       : clk, rst_n (async, active low)
//               start, alpha, beta, A, B, C, D - job request and operands
//               busy  - job in flight (RUN or DONE)
//               done  - one-cycle pulse, Cout updated in this cycle
//               Cout  - registered packed result
// Config      : GEMM_CTRL_SAT_EN - clamp each element to 2^W-1 instead of
//               keeping the low W bits of the accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
module gemm_ctrl
    import gemm_pkg::*;
#(
    parameter int N  = DEF_N,
    parameter int W  = DEF_W,
    parameter int SW = DEF_SW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [SW-1:0]     alpha,
    input  logic [SW-1:0]     beta,
    input  logic [N*N*W-1:0]  A,
    input  logic [N*N*W-1:0]  B,
    input  logic [N*N*W-1:0]  C,
    input  logic [N*N*W-1:0]  D,
    output logic              busy,
    output logic              done,
    output logic [N*N*W-1:0]  Cout
);

    localparam int             ACC_W = acc_w(W, SW, N);
    localparam int             MW    = N * N * W;
    localparam int             IW    = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0]  LAST  = IW'(N - 1);

    state_t            state_q, state_d;
    logic [IW-1:0]     i_q, i_d, j_q, j_d, k_q, k_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [SW-1:0]     alpha_q, alpha_d, beta_q, beta_d;
    logic [MW-1:0]     a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
    logic [W-1:0]      shadow_q [N][N];
    logic [W-1:0]      shadow_d [N][N];
    logic [MW-1:0]     cout_q, cout_d;
    logic              done_q, done_d;

    logic [W-1:0]      w_a_m [N][N];
    logic [W-1:0]      w_b_m [N][N];
    logic [W-1:0]      w_c_m [N][N];
    logic [W-1:0]      w_d_m [N][N];
    logic [ACC_W-1:0]  w_acc_next;
    logic [W-1:0]      w_red;
    logic              w_k_last;
    logic              w_last_step;
    logic [MW-1:0]     w_shadow_pk;

    // Unpack captured operands and repack the next shadow at fixed positions.
    genvar r, c;
    generate
        for (r = 0; r < N; r++) begin : g_row
            for (c = 0; c < N; c++) begin : g_col
                assign w_a_m[r][c] = a_q[elem_lsb(N, W, r, c) +: W];
                assign w_b_m[r][c] = b_q[elem_lsb(N, W, r, c) +: W];
                assign w_c_m[r][c] = c_q[elem_lsb(N, W, r, c) +: W];
                assign w_d_m[r][c] = d_q[elem_lsb(N, W, r, c) +: W];
                assign w_shadow_pk[elem_lsb(N, W, r, c) +: W] = shadow_d[r][c];
            end
        end
    endgenerate

    gemm_mac #(
        .W     (W),
        .SW    (SW),
        .ACC_W (ACC_W)
    ) u_mac (
        .alpha_i (alpha_q),
        .beta_i  (beta_q),
        .a_i     (w_a_m[i_q][k_q]),
        .b_i     (w_b_m[k_q][j_q]),
        .c_i     (w_c_m[i_q][k_q]),
        .d_i     (w_d_m[k_q][j_q]),
        .acc_i   (acc_q),
        .acc_o   (w_acc_next)
    );

`ifdef GEMM_CTRL_SAT_EN
    assign w_red = (|w_acc_next[ACC_W-1:W]) ? {W{1'b1}} : w_acc_next[W-1:0];
`else
    assign w_red = w_acc_next[W-1:0];
`endif

    assign w_k_last    = (state_q == RUN) && (k_q == LAST);
    assign w_last_step = w_k_last && (j_q == LAST) && (i_q == LAST);

    // Shadow gets the reduced dot product when the k loop closes.
    always_comb begin
        shadow_d = shadow_q;
        if (w_k_last) begin
            shadow_d[i_q][j_q] = w_red;
        end
    end

    // Next-state and datapath control.
    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;
        acc_d   = acc_q;
        alpha_d = alpha_q;
        beta_d  = beta_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        d_d     = d_q;
        cout_d  = cout_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    alpha_d = alpha;
                    beta_d  = beta;
                    a_d     = A;
                    b_d     = B;
                    c_d     = C;
                    d_d     = D;
                    i_d     = '0;
                    j_d     = '0;
                    k_d     = '0;
                    acc_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d = w_acc_next;
                k_d   = k_q + IW'(1);
                if (w_k_last) begin
                    acc_d = '0;
                    k_d   = '0;
                    if (j_q == LAST) begin
                        j_d = '0;
                        i_d = (i_q == LAST) ? '0 : i_q + IW'(1);
                    end else begin
                        j_d = j_q + IW'(1);
                    end
                end
                // Publishing on entry to DONE makes done and the new Cout
                // visible together during the DONE cycle.
                if (w_last_step) begin
                    cout_d  = w_shadow_pk;
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            acc_q   <= '0;
            alpha_q <= '0;
            beta_q  <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            d_q     <= '0;
            cout_q  <= '0;
            done_q  <= 1'b0;
            for (int rr = 0; rr < N; rr++) begin
                for (int cc = 0; cc < N; cc++) begin
                    shadow_q[rr][cc] <= '0;
                end
            end
        end else begin
            state_q  <= state_d;
            i_q      <= i_d;
            j_q      <= j_d;
            k_q      <= k_d;
            acc_q    <= acc_d;
            alpha_q  <= alpha_d;
            beta_q   <= beta_d;
            a_q      <= a_d;
            b_q      <= b_d;
            c_q      <= c_d;
            d_q      <= d_d;
            cout_q   <= cout_d;
            done_q   <= done_d;
            shadow_q <= shadow_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign Cout = cout_q;

endmodule
`default_nettype wire

// File: tb/tb_gemm_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_gemm_ctrl
// Description : Directed self-checking bench for gemm_ctrl (N=2, W=8, SW=8).
//               Expected results are hand-computed matrix products.
//               Honours GEMM_CTRL_SAT_EN for the overflow vector.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gemm_ctrl;

    localparam logic [31:0] c_IDENT = 32'h01000001;
    localparam logic [31:0] c_BMAT  = 32'h01020304;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  alpha = '0;
    logic [7:0]  beta  = '0;
    logic [31:0] A = '0, B = '0, C = '0, D = '0;
    logic        busy;
    logic        done;
    logic [31:0] Cout;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    gemm_ctrl #(.N(2), .W(8), .SW(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .alpha (alpha),
        .beta  (beta),
        .A     (A),
        .B     (B),
        .C     (C),
        .D     (D),
        .busy  (busy),
        .done  (done),
        .Cout  (Cout)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // One isolated job; operands are scrambled right after the accepting
    // edge so a missed capture shows up in the result.
    task automatic run_job(input string tag, input logic [7:0] al,
                           input logic [7:0] be, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] c,
                           input logic [31:0] d, input logic [31:0] exp);
        logic [31:0] prev, cout_at_done;
        int          done_cyc, pulses;
        bit          stable, busy_ok;
        @(negedge clk);
        alpha = al; beta = be; A = a; B = b; C = c; D = d;
        start = 1'b1;
        prev  = Cout;
        @(negedge clk);
        start = 1'b0;
        alpha = ~al; beta = ~be; A = ~a; B = ~b; C = ~c; D = ~d;
        done_cyc = 0; pulses = 0; stable = 1'b1; busy_ok = 1'b1;
        cout_at_done = '0;
        for (int cyc = 1; cyc <= 11; cyc++) begin
            if (done === 1'b1) begin
                pulses++;
                if (done_cyc == 0) begin
                    done_cyc     = cyc;
                    cout_at_done = Cout;
                end
            end
            if (cyc <= 8 && Cout !== prev) stable = 1'b0;
            if (busy !== (cyc <= 9)) busy_ok = 1'b0;
            @(negedge clk);
        end
        check({tag, "_done_cycle"}, 64'(done_cyc), 64'd9);
        check({tag, "_pulses"},     64'(pulses), 64'd1);
        check({tag, "_hold"},       64'(stable), 64'd1);
        check({tag, "_busy"},       64'(busy_ok), 64'd1);
        check({tag, "_cout_done"},  64'(cout_at_done), 64'(exp));
        check({tag, "_cout_after"}, 64'(Cout), 64'(exp));
    endtask

    logic [31:0] exp_ovf;
    int          p1, p2, npulse;
    bit          busy_ok, cout_ok;

    initial begin
`ifdef GEMM_CTRL_SAT_EN
        exp_ovf = 32'hFFFFFFFF;
`else
        exp_ovf = 32'h02020202;
`endif
        // Reset state
        #2;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_cout", 64'(Cout), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_job("ab",   8'd2, 8'd1, c_IDENT, c_BMAT, 32'h0, 32'h0, 32'h02040608);
        run_job("abcd", 8'd2, 8'd1, c_IDENT, c_BMAT, c_IDENT, c_IDENT, 32'h03040609);
        run_job("ovf",  8'd1, 8'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0, exp_ovf);

        // Back-to-back with ignored starts at cycles 3 and 9.
        @(negedge clk);
        A = c_IDENT; B = c_BMAT; C = '0; D = '0; alpha = 8'd1; beta = 8'd0;
        start = 1'b1;
        p1 = 0; p2 = 0; npulse = 0; busy_ok = 1'b1; cout_ok = 1'b1;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                npulse++;
                if (p1 == 0) p1 = cyc;
                else if (p2 == 0) p2 = cyc;
            end
            if (busy !== (cyc != 10 && cyc != 20)) busy_ok = 1'b0;
            if (cyc <= 8 && Cout !== exp_ovf) cout_ok = 1'b0;
            if (cyc >= 9 && cyc <= 18 && Cout !== 32'h01020304) cout_ok = 1'b0;
            if (cyc >= 19 && Cout !== 32'h0306090C) cout_ok = 1'b0;
            start = (cyc == 3 || cyc == 9 || cyc == 10);
            if (cyc == 3 || cyc == 9) begin
                alpha = 8'hFF; B = 32'hFFFFFFFF;
            end
            if (cyc == 10) begin
                A = c_IDENT; B = c_BMAT; C = '0; D = '0;
                alpha = 8'd3; beta = 8'd0;
            end
        end
        start = 1'b0;
        check("b2b_first_done",  64'(p1), 64'd9);
        check("b2b_second_done", 64'(p2), 64'd19);
        check("b2b_pulses",      64'(npulse), 64'd2);
        check("b2b_busy",        64'(busy_ok), 64'd1);
        check("b2b_cout_track",  64'(cout_ok), 64'd1);
        check("b2b_cout_final",  64'(Cout), 64'h0306090C);

        // Abort with reset at cycle 4 of a job.
        @(negedge clk);
        A = c_IDENT; B = c_BMAT; C = '0; D = '0; alpha = 8'd2; beta = 8'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_cout", 64'(Cout), 64'd0);
        npulse = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            @(negedge clk);
            if (cyc == 2) rst_n = 1'b1;
            if (done === 1'b1) npulse++;
        end
        check("abort_no_done", 64'(npulse), 64'd0);
        check("abort_idle",    64'(busy), 64'd0);

        run_job("post_rst", 8'd2, 8'd0, c_IDENT, c_BMAT, 32'h0, 32'h0, 32'h02040608);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
